// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer that owns the HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, sign fix-up on the last step.
module muldiv_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    input  logic              wr_hi,
    input  logic              wr_lo,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall_req,
    output logic              busy,
    output logic              valid_o,
    output logic              div_zero_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // state  | meaning
    // IDLE   | no op in flight, MTHI/MTLO accepted
    // MUL    | shift-add multiply iterations
    // DIV    | restoring divide iterations
    // DONE   | one-cycle result strobe, may accept the next op
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] acc_hi;
    logic [DATA_W-1:0] acc_lo;
    logic              neg_q;
    logic              neg_r;
    logic              dz_flag;

    logic              idle_or_done;
    logic              accept;
    logic              a_neg;
    logic              b_neg;
    logic              b_zero;
    logic              last;
    logic [DATA_W-1:0] abs_a;
    logic [DATA_W-1:0] abs_b;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W-1:0]   mul_hi_n;
    logic [DATA_W-1:0]   mul_lo_n;
    logic [DATA_W:0]     div_shift;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [DATA_W-1:0]   div_hi_n;
    logic [DATA_W-1:0]   div_lo_n;
    logic [2*DATA_W-1:0] prod;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix;
    logic [DATA_W-1:0]   rem_fix;

    assign idle_or_done = (state == S_IDLE) || (state == S_DONE);
    assign accept       = start && !cancel && idle_or_done;
    assign a_neg        = !op[0] && src_a[DATA_W-1];
    assign b_neg        = !op[0] && src_b[DATA_W-1];
    assign abs_a        = a_neg ? -src_a : src_a;
    assign abs_b        = b_neg ? -src_b : src_b;
    assign b_zero       = op[1] && (src_b == '0);
    assign last         = (cnt == CNT_W'(DATA_W - 1));

    // Multiply: {acc_hi, acc_lo} holds partial product and the unconsumed multiplier bits.
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign mul_hi_n = mul_sum[DATA_W:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[DATA_W-1:1]};

    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift - {1'b0, opnd};
    assign div_hi_n  = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
    assign div_lo_n  = {acc_lo[DATA_W-2:0], div_ge};

    assign prod     = {mul_hi_n, mul_lo_n};
    assign prod_fix = neg_q ? -prod : prod;
    assign quot_fix = neg_q ? -div_lo_n : div_lo_n;
    assign rem_fix  = neg_r ? -div_hi_n : div_hi_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            opnd    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dz_flag <= 1'b0;
            hi_o    <= '0;
            lo_o    <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (wr_hi) hi_o <= wr_data;
                    if (wr_lo) lo_o <= wr_data;
                    state <= S_IDLE;
                    if (accept) begin
                        cnt     <= '0;
                        acc_hi  <= '0;
                        neg_q   <= a_neg ^ b_neg;
                        neg_r   <= a_neg;
                        dz_flag <= b_zero;
                        if (op[1]) begin
                            opnd   <= abs_b;
                            acc_lo <= abs_a;
                            // A zero divisor resolves immediately and wins over MTHI/MTLO.
                            if (b_zero) begin
                                state <= S_DONE;
                                hi_o  <= src_a;
                                lo_o  <= '1;
                            end else begin
                                state <= S_DIV;
                            end
                        end else begin
                            opnd   <= abs_a;
                            acc_lo <= abs_b;
                            state  <= S_MUL;
                        end
                    end
                end
                default: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= (state == S_DIV) ? div_hi_n : mul_hi_n;
                        acc_lo <= (state == S_DIV) ? div_lo_n : mul_lo_n;
                        cnt    <= cnt + 1'b1;
                        if (last) begin
                            state <= S_DONE;
                            if (state == S_DIV) begin
                                hi_o <= rem_fix;
                                lo_o <= quot_fix;
                            end else begin
                                hi_o <= prod_fix[2*DATA_W-1:DATA_W];
                                lo_o <= prod_fix[DATA_W-1:0];
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign busy       = (state != S_IDLE);
    assign valid_o    = (state == S_DONE);
    assign div_zero_o = valid_o && dz_flag;
    assign stall_req  = (start && (state == S_IDLE) && !cancel) ||
                        (state == S_MUL) || (state == S_DIV);

endmodule
